// File: rtl/assay_seq_pkg.sv
// Shared types and constants for the assay dose sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package assay_seq_pkg;

  // Sequencer phases; DOSE also covers the single empty cycle when no inlet qualifies
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOSE,
    ST_MIX,
    ST_FLUSH,
    ST_DONE
  } seq_state_t;

  localparam int CNT_W_DEF = 16;  // default width of dwell/mix/flush counts
  localparam int N_CH_MAX  = 16;  // largest supported number of reagent inlets

endpackage

// File: rtl/seg_timer.sv
// Segment down-counter shared by every dose/mix/flush segment of the sequencer.
// Latency: load takes effect at the next edge; zero reflects the registered count.
// Backpressure: none; the counter holds at zero until reloaded.
module seg_timer
  import assay_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load length-1 on segment entry, then count down and stick at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/assay_dose_sequencer.sv
// Programmable inlet-dose / mix / flush valve sequencer; option macro SEQ_ABORT_FLUSH_EN flushes the outlet on abort.
// Latency: all outputs registered; busy and the first open valve rise the cycle after start is sampled.
// Backpressure: none; start is ignored while a run is in progress, inputs are latched at start.
module assay_dose_sequencer
  import assay_seq_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic [N_CH*CNT_W-1:0] dwell,
  input  logic [CNT_W-1:0]      mix_cycles,
  input  logic [CNT_W-1:0]      flush_cycles,
  output logic [N_CH-1:0]       valve_o,
  output logic                  mix_pump_o,
  output logic                  flush_o,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] C1 = CNT_W'(1);

  seq_state_t state, n_state;
  logic [CH_W-1:0]       cur_ch, n_ch;
  logic [N_CH-1:0]       sh_mask;
  logic [N_CH*CNT_W-1:0] sh_dwell;
  logic [CNT_W-1:0]      sh_mix, sh_flush;

  logic [N_CH-1:0]  n_valve;
  logic             n_mix, n_flush, n_busy, n_done, n_abrt, lat;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             enter_mix, enter_flush, enter_done;

  logic             live_hit, sh_hit;
  logic [CH_W-1:0]  live_ch, sh_ch;
  logic [N_CH-1:0]  live_oh, sh_oh;
  logic [CNT_W-1:0] live_len, sh_len;

`ifdef SEQ_ABORT_FLUSH_EN
  logic ab_flush, n_abf;
`endif

  seg_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Priority encoders: lowest qualifying inlet in the live inputs, and above cur_ch in the shadow copy
  always_comb begin
    live_hit = 1'b0; live_ch = '0; live_oh = '0; live_len = '0;
    sh_hit   = 1'b0; sh_ch   = '0; sh_oh   = '0; sh_len   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i] && (dwell[i*CNT_W +: CNT_W] != '0)) begin
        live_hit = 1'b1;
        live_ch  = CH_W'(i);
        live_oh  = '0;
        live_oh[i] = 1'b1;
        live_len = dwell[i*CNT_W +: CNT_W];
      end
      if (sh_mask[i] && (sh_dwell[i*CNT_W +: CNT_W] != '0) && (i > int'(cur_ch))) begin
        sh_hit = 1'b1;
        sh_ch  = CH_W'(i);
        sh_oh  = '0;
        sh_oh[i] = 1'b1;
        sh_len = sh_dwell[i*CNT_W +: CNT_W];
      end
    end
  end

  // Next phase, next registered drives and timer reload; zero-length segments fall through in one step
  always_comb begin
    n_state = state;   n_ch = cur_ch;   n_valve = valve_o;
    n_mix = mix_pump_o; n_flush = flush_o; n_busy = busy;
    n_done = 1'b0;     n_abrt = 1'b0;   lat = 1'b0;
    tmr_load = 1'b0;   tmr_val = '0;
    enter_mix = 1'b0;  enter_flush = 1'b0; enter_done = 1'b0;
`ifdef SEQ_ABORT_FLUSH_EN
    n_abf = ab_flush;
`endif
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          lat = 1'b1; n_busy = 1'b1; n_state = ST_DOSE; tmr_load = 1'b1;
          n_ch    = live_hit ? live_ch : '0;
          n_valve = live_hit ? live_oh : '0;
          tmr_val = live_hit ? (live_len - C1) : '0;
        end
      end
      ST_DOSE: begin
        if (tmr_zero) begin
          n_valve = '0;
          if (sh_hit) begin
            n_ch = sh_ch; n_valve = sh_oh; tmr_load = 1'b1; tmr_val = sh_len - C1;
          end else begin
            enter_mix = 1'b1;
          end
        end
      end
      ST_MIX: begin
        if (tmr_zero) begin
          n_mix = 1'b0; enter_flush = 1'b1;
        end
      end
      ST_FLUSH: begin
`ifdef SEQ_ABORT_FLUSH_EN
        if (ab_flush) begin
          // aborted marks the final flush cycle of an abort-induced flush
          if (aborted) begin
            n_state = ST_IDLE; n_flush = 1'b0; n_busy = 1'b0; n_abf = 1'b0;
          end else if (tmr_zero) begin
            n_abrt = 1'b1;
          end
        end else
`endif
        if (tmr_zero) begin
          n_flush = 1'b0; enter_done = 1'b1;
        end
      end
      ST_DONE: begin
        n_state = ST_IDLE; n_busy = 1'b0;
      end
      default: n_state = ST_IDLE;
    endcase

    if (enter_mix) begin
      if (sh_mix != '0) begin
        n_state = ST_MIX; n_mix = 1'b1; tmr_load = 1'b1; tmr_val = sh_mix - C1;
      end else begin
        enter_flush = 1'b1;
      end
    end
    if (enter_flush) begin
      if (sh_flush != '0) begin
        n_state = ST_FLUSH; n_flush = 1'b1; tmr_load = 1'b1; tmr_val = sh_flush - C1;
      end else begin
        enter_done = 1'b1;
      end
    end
    if (enter_done) begin
      n_state = ST_DONE; n_done = 1'b1; n_valve = '0; n_mix = 1'b0; n_flush = 1'b0;
    end

`ifdef SEQ_ABORT_FLUSH_EN
    // Abort in DOSE/MIX diverts to a flush of at least one cycle; the last flush cycle carries aborted
    if (abort && (state == ST_DOSE || state == ST_MIX)) begin
      n_state = ST_FLUSH; n_valve = '0; n_mix = 1'b0; n_flush = 1'b1; n_done = 1'b0;
      n_abf = 1'b1; tmr_load = 1'b1;
      if (sh_flush <= C1) begin
        n_abrt = 1'b1; tmr_val = '0;
      end else begin
        n_abrt = 1'b0; tmr_val = sh_flush - CNT_W'(2);
      end
    end
`else
    // Abort in any active phase drops every drive and returns straight to IDLE
    if (abort && (state == ST_DOSE || state == ST_MIX || state == ST_FLUSH)) begin
      n_state = ST_IDLE; n_valve = '0; n_mix = 1'b0; n_flush = 1'b0;
      n_busy = 1'b0; n_done = 1'b0; n_abrt = 1'b1; tmr_load = 1'b0;
    end
`endif
  end

  // Register phase, drives, status pulses and the run configuration captured at start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE; cur_ch <= '0; valve_o <= '0;
      mix_pump_o <= 1'b0; flush_o <= 1'b0; busy <= 1'b0; done <= 1'b0; aborted <= 1'b0;
      sh_mask <= '0; sh_dwell <= '0; sh_mix <= '0; sh_flush <= '0;
`ifdef SEQ_ABORT_FLUSH_EN
      ab_flush <= 1'b0;
`endif
    end else begin
      state <= n_state; cur_ch <= n_ch; valve_o <= n_valve;
      mix_pump_o <= n_mix; flush_o <= n_flush; busy <= n_busy; done <= n_done; aborted <= n_abrt;
`ifdef SEQ_ABORT_FLUSH_EN
      ab_flush <= n_abf;
`endif
      if (lat) begin
        sh_mask <= ch_mask; sh_dwell <= dwell; sh_mix <= mix_cycles; sh_flush <= flush_cycles;
      end
    end
  end

endmodule

// File: tb/tb_assay_dose_sequencer.sv
// Randomised bench for assay_dose_sequencer against a segment-list reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; every run has a fixed, model-derived cycle count.
module tb_assay_dose_sequencer;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int PH_DOSE = 0, PH_MIX = 1, PH_FLUSH = 2, PH_DONE = 3, PH_IDLE = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, abort;
  logic [NCH-1:0]  ch_mask;
  logic [NCH*CW-1:0] dwell;
  logic [CW-1:0]   mix_cycles, flush_cycles;
  logic [NCH-1:0]  valve_o;
  logic            mix_pump_o, flush_o, busy, done, aborted;
  logic [7:0]      obs;

  int checks = 0;
  int errors = 0;

  logic [2:0] cfg_mask;
  int         cfg_dw [NCH];
  int         cfg_mix, cfg_flush, cfg_ab;
  logic [7:0] exp_q [$];
  int         ph_q  [$];

  assay_dose_sequencer #(.N_CH(NCH), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .ch_mask      (ch_mask),
    .dwell        (dwell),
    .mix_cycles   (mix_cycles),
    .flush_cycles (flush_cycles),
    .valve_o      (valve_o),
    .mix_pump_o   (mix_pump_o),
    .flush_o      (flush_o),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  assign obs = {valve_o, mix_pump_o, flush_o, busy, done, aborted};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic [2:0] v, input logic p, input logic f,
                                    input logic b, input logic d, input logic a);
    return {v, p, f, b, d, a};
  endfunction

  task automatic push(input logic [7:0] v, input int ph);
    exp_q.push_back(v);
    ph_q.push_back(ph);
  endtask

  // Expected per-cycle outputs from the cycle after start: inlets, mix, flush, done, then abort edits
  task automatic build_model();
    bit any = 1'b0;
    int a;
    exp_q.delete();
    ph_q.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      if (cfg_mask[ch] && cfg_dw[ch] > 0) begin
        any = 1'b1;
        for (int k = 0; k < cfg_dw[ch]; k++) push(mk(3'(1 << ch), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), PH_DOSE);
      end
    end
    if (!any) push(mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), PH_DOSE);
    for (int k = 0; k < cfg_mix; k++)   push(mk(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), PH_MIX);
    for (int k = 0; k < cfg_flush; k++) push(mk(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), PH_FLUSH);
    push(mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), PH_DONE);
    a = cfg_ab;
    if (a > 0 && a <= exp_q.size() && ph_q[a-1] != PH_DONE) begin
`ifdef SEQ_ABORT_FLUSH_EN
      if (ph_q[a-1] != PH_FLUSH) begin
        int fl;
        while (exp_q.size() > a) begin void'(exp_q.pop_back()); void'(ph_q.pop_back()); end
        fl = (cfg_flush > 0) ? cfg_flush : 1;
        for (int k = 0; k < fl; k++)
          push(mk(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, (k == fl - 1)), PH_FLUSH);
      end
`else
      while (exp_q.size() > a) begin void'(exp_q.pop_back()); void'(ph_q.pop_back()); end
      push(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), PH_IDLE);
`endif
    end
    push(8'h00, PH_IDLE);
    push(8'h00, PH_IDLE);
  endtask

  task automatic set_cfg(input logic [2:0] m, input int d0, input int d1, input int d2,
                         input int mx, input int fl, input int ab);
    cfg_mask = m; cfg_dw[0] = d0; cfg_dw[1] = d1; cfg_dw[2] = d2;
    cfg_mix = mx; cfg_flush = fl; cfg_ab = ab;
  endtask

  task automatic apply_cfg();
    ch_mask      = cfg_mask;
    dwell        = {CW'(cfg_dw[2]), CW'(cfg_dw[1]), CW'(cfg_dw[0])};
    mix_cycles   = CW'(cfg_mix);
    flush_cycles = CW'(cfg_flush);
  endtask

  // One run: start in IDLE, then per cycle compare and scramble the live inputs while busy
  task automatic do_run(input string name);
    build_model();
    apply_cfg();
    start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < exp_q.size(); c++) begin
      chk($sformatf("%s_c%0d", name, c + 1), 32'(obs), 32'(exp_q[c]));
      start = 1'b0; abort = 1'b0;
      if (exp_q[c][2]) begin
        ch_mask      = 3'($urandom);
        dwell        = {CW'($urandom), CW'($urandom), CW'($urandom)};
        mix_cycles   = CW'($urandom_range(0, 9));
        flush_cycles = CW'($urandom_range(0, 9));
        start        = 1'($urandom_range(0, 1));
      end
      if (c + 1 == cfg_ab) abort = 1'b1;
      else if (cfg_ab == 0 && ph_q[c] == PH_DONE) abort = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    ch_mask = '0; dwell = '0; mix_cycles = '0; flush_cycles = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset", 32'(obs), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("idle", 32'(obs), 32'd0);

    // start and abort together in IDLE do nothing
    set_cfg(3'b111, 2, 3, 5, 4, 2, 0);
    apply_cfg();
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort", 32'(obs), 32'd0);

    set_cfg(3'b111, 2, 3, 5, 4, 2, 0);  do_run("full");
    set_cfg(3'b101, 0, 3, 4, 0, 3, 0);  do_run("skip");
    set_cfg(3'b000, 4, 4, 4, 0, 0, 0);  do_run("empty");
    set_cfg(3'b111, 2, 3, 5, 5, 3, 13); do_run("abort_mix");
    set_cfg(3'b011, 3, 2, 1, 2, 0, 2);  do_run("abort_dose");
    set_cfg(3'b001, 65535, 0, 0, 1, 0, 0); do_run("max_dwell");

    for (int r = 0; r < 40; r++) begin
      set_cfg(3'($urandom),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 25)) : 0);
      do_run($sformatf("rnd%0d", r));
    end

    // asynchronous reset in the middle of DOSE clears outputs within the same cycle
    set_cfg(3'b111, 2, 3, 5, 4, 2, 0);
    apply_cfg();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst", 32'(obs), 32'(mk(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    #3 rst = 1'b1;
    #1 chk("rst_async", 32'(obs), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", 32'(obs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assay_dose_sequencer.md
# assay_dose_sequencer

Clocked valve/pump sequencer for the next-generation multi-reagent assay chip. It generalises the fixed three-inlet, serpentine-delayed dosing path into a run-time programmable sequence over `N_CH` reagent inlets. Each enabled inlet valve opens for a programmed dwell, then the mixer pump runs, then the outlet is flushed. It sits between the host control register file and the chip's valve/pump drivers.

## Interface
- `N_CH`, 3: number of reagent inlet valves (1..16).
- `CNT_W`, 16: width of every dwell/mix/flush cycle count.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a run; sampled only in IDLE.
- `abort` input 1: terminate the current run.
- `ch_mask` input N_CH: 1 = inlet participates in the run.
- `dwell` input N_CH*CNT_W: per-inlet open time in cycles; channel i occupies bits [i*CNT_W +: CNT_W].
- `mix_cycles` input CNT_W: mixer pump on-time.
- `flush_cycles` input CNT_W: outlet flush on-time.
- `valve_o` output N_CH: inlet valve drives, at most one bit high.
- `mix_pump_o` output 1: mixer pump drive.
- `flush_o` output 1: outlet flush valve drive.
- `busy` output 1: high from accepted start until return to IDLE.
- `done` output 1: one-cycle pulse on normal completion.
- `aborted` output 1: one-cycle pulse when a run ends via abort.

## Operation
- States: IDLE, DOSE, MIX, FLUSH, DONE.
- IDLE → DOSE when `start`=1 and `abort`=0.
  - On that edge, `ch_mask`, `dwell`, `mix_cycles` and `flush_cycles` are latched into shadow registers.
  - Later input changes do not affect the running sequence.
- DOSE visits channels in ascending index.
  - A channel is skipped (zero cycles) if its latched mask bit is 0 or its dwell is 0.
  - `valve_o[i]` is high for exactly `dwell[i]` cycles.
  - The next channel's valve opens on the cycle after the previous one closes. There are no gap cycles and never two valves open at once.
- After the last channel, DOSE → MIX. If no channel qualifies, DOSE occupies one cycle with all valves low.
- MIX: `mix_pump_o` is high for `mix_cycles` cycles. If the count is 0, MIX is skipped.
- FLUSH: `flush_o` is high for `flush_cycles` cycles. If the count is 0, FLUSH is skipped.
- DONE: lasts one cycle, `done`=1, then → IDLE.
- Abort:
  - In DOSE, MIX or FLUSH, `abort`=1 forces all drive outputs low on the next cycle and pulses `aborted`.
  - `abort` in IDLE or DONE is ignored.
  - `start` and `abort` together in IDLE: nothing happens.
- Counting uses a down-counter. It loads count−1 on segment entry, and the segment ends when the counter reaches 0. The maximum dwell is 2^CNT_W−1 cycles, with no wrap.

## Timing
- Reset values: state IDLE; `valve_o`=0, `mix_pump_o`=0, `flush_o`=0, `busy`=0, `done`=0, `aborted`=0; shadow registers 0.
- All outputs are registered.
- Start latency: if `start` is sampled at edge k, then `busy` and the first qualifying valve are high from cycle k+1.
- Total run length = 1 (DOSE-empty only) + Σ qualifying dwells + mix + flush + 1 (DONE) cycles.
- `busy` drops in the cycle after DONE.
- `start` is accepted again in the first IDLE cycle.
- Reset asserted mid-run: all outputs go low immediately (asynchronous), with no `done`/`aborted` pulse.

## Configuration
- `SEQ_ABORT_FLUSH_EN` defined:
  - An abort in DOSE or MIX goes to FLUSH and runs the latched `flush_cycles` (forced to a minimum of 1 cycle).
  - It then goes to IDLE, pulsing `aborted` on the last flush cycle instead of `done`.
  - An abort during FLUSH lets the flush complete.
- Undefined: an abort goes directly to IDLE as described in Operation.

## Structure
- Package `assay_seq_pkg` holds:
  - the state enum type;
  - the default `CNT_W`;
  - the `N_CH` limit constant.
- Sub-module `seg_timer`: a CNT_W down-counter with `load`, `load_val`, and a `zero` flag. It is instantiated once and shared across all segments.
- The next-channel search is a priority encoder over (mask & dwell≠0) above the current index. It is combinational inside the top module.

## Test plan
- N_CH=3, mask=3'b111, dwell={5,3,2} (ch2,ch1,ch0), mix=4, flush=2: `valve_o[0]` high 2 cycles, then [1] for 3, then [2] for 5; pump 4; flush 2; `done` at cycle 17 after start; `busy` 17 cycles.
- mask=3'b101, dwell[0]=0: ch0 and ch1 are skipped, so only `valve_o[2]` opens; a mix=0 run shows no pump cycle.
- mask=0, mix=0, flush=0: exactly DOSE (1 cycle) then DONE; `done` is at cycle 2 after start.
- Abort on the 3rd cycle of MIX:
  - macro undefined: outputs are low next cycle, `aborted` pulses once, `done` never pulses;
  - macro defined: `flush_o` is high for `flush_cycles`, then `aborted`.
- Change `dwell` and `ch_mask` mid-run, and pulse `start` during a run: timing is unchanged and no restart occurs. Assert `rst` mid-DOSE: all outputs are 0 in the same cycle.
